// File: rtl/legv8_pkg.sv
// Shared definitions for the 64-bit LEGv8 pipeline.
// - Default datapath and control-bundle widths.
// - Bit positions inside the control bundle carried down the pipe.
// - The architectural zero register number.
package legv8_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned CTRL_W = 8;

  // Control bundle bit map
  localparam int unsigned REGWRITE = 0;
  localparam int unsigned MEMREAD  = 1;
  localparam int unsigned MEMWRITE = 2;
  localparam int unsigned MEMTOREG = 3;
  localparam int unsigned ALUSRC   = 4;
  localparam int unsigned BRANCH   = 5;
  localparam int unsigned ALUOP_LO = 6;
  localparam int unsigned ALUOP_HI = 7;

  // XZR reads as zero, so it can never carry a load-use dependency
  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the decode instruction and the one in EX.
// Inputs : id_valid, id_read1, id_read2      - decode instruction and its sources
//          ex_valid, ex_memread, ex_write_reg - instruction currently in EX
//          flush, hold                        - pipeline control
// Outputs: hazard    - decode instruction needs the result of a load still in EX
//          stall_out - hold PC and IF/ID this cycle
module hazard_detect
  import legv8_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_read1,
  input  logic [4:0] id_read2,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_write_reg,
  input  logic       flush,
  input  logic       hold,
  output logic       hazard,
  output logic       stall_out
);

  logic src_match;

  always_comb begin
    src_match = (ex_write_reg == id_read1) || (ex_write_reg == id_read2);
    hazard    = id_valid && ex_valid && ex_memread && (ex_write_reg != XZR) && src_match;
    // A flush kills the decode instruction, so there is nothing left to stall for
    stall_out = (hazard || hold) && !flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 64-bit LEGv8 datapath.
// Inputs : clock, reset_n (async, active low), id_* decode fields, flush, hold
// Outputs: ex_* registered copies of the decode fields, ex_valid,
//          stall_out (combinational load-use / hold stall),
//          stall_count (saturating count of load-use bubbles)
module id_ex_stage
  import legv8_pkg::*;
#(
  parameter int unsigned XLEN   = legv8_pkg::XLEN,
  parameter int unsigned CTRL_W = legv8_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [4:0]        id_read1,
  input  logic [4:0]        id_read2,
  input  logic [4:0]        id_write_reg,
  input  logic [XLEN-1:0]   id_data1,
  input  logic [XLEN-1:0]   id_data2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_data1,
  output logic [XLEN-1:0]   ex_data2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_read1,
  output logic [4:0]        ex_read2,
  output logic [4:0]        ex_write_reg,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  logic              hazard;
  logic              valid_q;
  logic [XLEN-1:0]   data1_q, data2_q, imm_q, pc_q;
  logic [4:0]        read1_q, read2_q, write_reg_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  hazard_detect u_hazard_detect (
    .id_valid     (id_valid),
    .id_read1     (id_read1),
    .id_read2     (id_read2),
    .ex_valid     (valid_q),
    .ex_memread   (ctrl_q[MEMREAD]),
    .ex_write_reg (write_reg_q),
    .flush        (flush),
    .hold         (hold),
    .hazard       (hazard),
    .stall_out    (stall_out)
  );

  // Priority: flush, hold, hazard bubble, normal load. Bubbles and flushes zero the
  // control bundle so no write or memory access can leak out of a dead slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      read1_q     <= '0;
      read2_q     <= '0;
      write_reg_q <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (hold) begin
      // freeze everything, including the counter
    end else if (hazard) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end else begin
      valid_q     <= id_valid;
      data1_q     <= id_data1;
      data2_q     <= id_data2;
      imm_q       <= id_imm;
      pc_q        <= id_pc;
      read1_q     <= id_read1;
      read2_q     <= id_read2;
      write_reg_q <= id_write_reg;
      ctrl_q      <= id_valid ? id_ctrl : '0;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_data1     = data1_q;
  assign ex_data2     = data2_q;
  assign ex_imm       = imm_q;
  assign ex_pc        = pc_q;
  assign ex_read1     = read1_q;
  assign ex_read2     = read2_q;
  assign ex_write_reg = write_reg_q;
  assign ex_ctrl      = ctrl_q;
  assign stall_count  = stall_cnt_q;

endmodule
